// File: rtl/core_isa_pkg.sv
// Shared ISA definitions for the fetch/decode boundary: opcode and immediate
// field positions, the branch opcode, the NOP encoding and the redirect states.
package core_isa_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 24;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    localparam logic [7:0]  BR_OPCODE = 8'h07;
    localparam logic [31:0] NOP       = 32'h0000_0000;

    typedef enum logic {
        IDLE,
        REDIRECT
    } redirect_state_t;

    function automatic logic [7:0] opcode_of(input logic [31:0] ins);
        return ins[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [15:0] imm_of(input logic [31:0] ins);
        return ins[IMM_MSB:IMM_LSB];
    endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Fetch-side and decode-side signals of the fetch redirect controller.
// master: the controller. slave: the fetch stage / decode environment.
interface fetch_redirect_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] fetch_pc;
    logic [31:0]       fetch_ins;
    logic              sel_br;
    logic [ADDR_W-1:0] br_targ;
    logic              pc_stall;
    logic              id_valid;
    logic              id_ready;
    logic [31:0]       id_ins;
    logic [ADDR_W-1:0] id_pc;

    modport master (
        input  fetch_pc, fetch_ins, id_ready,
        output sel_br, br_targ, pc_stall, id_valid, id_ins, id_pc
    );

    modport slave (
        output fetch_pc, fetch_ins, id_ready,
        input  sel_br, br_targ, pc_stall, id_valid, id_ins, id_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO holding {instruction, pc} pairs between fetch
// and decode. Push into a full FIFO and pop from an empty one are ignored.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[head];

    // Storage write at the tail; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            tail <= '0;
        end else if (do_push) begin
            mem[tail] <= din;
            tail      <= tail + PTR_W'(1);
        end
    end

    // Head pointer and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            count <= '0;
        end else begin
            if (do_pop) head <= head + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Decode-side receiver for the fetch stage: buffers fetched instructions,
// stalls fetch when the buffer is full and redirects fetch on an absolute
// branch, squashing the wrong-path slot that follows it.
// Build option FETCH_DELAY_SLOT_EN: the slot after a branch is kept as an
// architectural delay slot instead of being squashed.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no redirect in flight, every unstalled slot is captured
// REDIRECT | branch captured, sel_br high until fetch loads br_targ
module fetch_redirect_ctrl #(
    parameter int         DEPTH     = 2,
    parameter logic [7:0] BR_OPCODE = core_isa_pkg::BR_OPCODE,
    parameter int         ADDR_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fetch_redirect_ctrl_if.master bus
);
    import core_isa_pkg::*;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int W     = 32 + ADDR_W;

    redirect_state_t   state;
    logic              sel_br_q;
    logic [ADDR_W-1:0] br_targ_q;
    logic              br_pending;

    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic [W-1:0]      head;
    logic              is_br;

    assign br_pending = (state == REDIRECT);
    assign is_br      = (opcode_of(bus.fetch_ins) == BR_OPCODE);

`ifdef FETCH_DELAY_SLOT_EN
    assign push = !full;
`else
    assign push = !full && !br_pending;
`endif
    assign pop  = !empty && bus.id_ready;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({bus.fetch_ins, bus.fetch_pc - ADDR_W'(4)}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign bus.pc_stall = (count == CNT_W'(DEPTH));
    assign bus.id_valid = (count != '0);
    assign bus.id_ins   = bus.id_valid ? head[W-1 -: 32]    : NOP;
    assign bus.id_pc    = bus.id_valid ? head[ADDR_W-1:0]   : '0;
    assign bus.sel_br   = sel_br_q;
    assign bus.br_targ  = br_targ_q;

    // Redirect FSM: branch capture enters REDIRECT; leave once fetch is unstalled
    // and has therefore loaded br_targ. A branch in a delay slot is not tracked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel_br_q  <= 1'b0;
            br_targ_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (push && is_br) begin
                        state     <= REDIRECT;
                        sel_br_q  <= 1'b1;
                        br_targ_q <= ADDR_W'(imm_of(bus.fetch_ins));
                    end
                end
                REDIRECT: begin
                    if (!full) begin
                        state    <= IDLE;
                        sel_br_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    sel_br_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Randomized bench for fetch_redirect_ctrl: a small fetch-stage model walks an
// instruction memory, decode readiness is random, and a queue-based reference
// predicts every output each cycle.
module tb_fetch_redirect_ctrl;
    localparam int DEPTH = 2;
    localparam int NCYC  = 1500;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_redirect_ctrl_if #(.ADDR_W(32)) bus ();

    fetch_redirect_ctrl #(
        .DEPTH     (DEPTH),
        .BR_OPCODE (8'h07),
        .ADDR_W    (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // reference state
    logic [63:0] q[$];
    bit          pend;
    logic [31:0] targ;
    logic [31:0] p;
    logic [31:0] imem [64];

    task automatic model_reset();
        q.delete();
        pend = 1'b0;
        targ = '0;
        p    = '0;
    endtask

    task automatic check_outputs();
        logic [31:0] e_ins, e_pc;
        e_ins = (q.size() != 0) ? q[0][63:32] : 32'h0;
        e_pc  = (q.size() != 0) ? q[0][31:0]  : 32'h0;
        check("pc_stall", 32'(bus.pc_stall), 32'(q.size() == DEPTH));
        check("id_valid", 32'(bus.id_valid), 32'(q.size() != 0));
        check("id_ins",   bus.id_ins, e_ins);
        check("id_pc",    bus.id_pc,  e_pc);
        check("sel_br",   32'(bus.sel_br), 32'(pend));
        check("br_targ",  bus.br_targ, targ);
    endtask

    // Advance the reference across one posedge using the inputs now applied.
    task automatic model_step(input logic [31:0] ins, input logic [31:0] fpc, input bit rdy);
        bit stall, pop, push, old_pend;
        logic [31:0] old_targ;
        stall    = (q.size() == DEPTH);
        pop      = (q.size() != 0) && rdy;
        old_pend = pend;
        old_targ = targ;
`ifdef FETCH_DELAY_SLOT_EN
        push = !stall;
`else
        push = !stall && !pend;
`endif
        if (old_pend && !stall) pend = 1'b0;
        else if (!old_pend && push && ins[31:24] == 8'h07) begin
            pend = 1'b1;
            targ = {16'h0, ins[15:0]};
        end
        if (pop)  void'(q.pop_front());
        if (push) q.push_back({ins, fpc - 32'd4});
        if (!stall) p = old_pend ? old_targ : p + 32'd4;
    endtask

    function automatic bit ready_at(input int cyc);
        int thr;
        if (cyc < 4) return 1'b1;
        if (cyc < 8) return 1'b0;
        if (cyc < 20) return 1'b1;
        thr = ((cyc / 25) % 2 == 0) ? 35 : 90;
        return ($urandom_range(0, 99) < thr);
    endfunction

    initial begin
        bit          rdy;
        bit          did_rst;
        logic [31:0] ins;
        logic [31:0] fpc;
        logic [7:0]  op;

        imem[0] = 32'h0511_0003;
        imem[1] = 32'h0519_0005;
        imem[2] = 32'h0740_0024;
        for (int i = 3; i < 64; i++) begin
            if ($urandom_range(0, 4) == 0)
                imem[i] = {8'h07, 8'($urandom), 8'h00, 6'($urandom_range(0, 63)), 2'b00};
            else begin
                op = 8'($urandom);
                if (op == 8'h07) op = 8'h08;
                imem[i] = {op, 24'($urandom)};
            end
        end

        model_reset();
        bus.fetch_pc  = '0;
        bus.fetch_ins = '0;
        bus.id_ready  = 1'b0;
        did_rst       = 1'b0;

        repeat (3) @(negedge clk);
        check_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            check_outputs();
            ins = imem[p[7:2]];
            fpc = p + 32'd4;
            rdy = ready_at(cyc);
            bus.fetch_ins = ins;
            bus.fetch_pc  = fpc;
            bus.id_ready  = rdy;

            if (!did_rst && cyc > 200 && pend && q.size() != 0) begin
                did_rst = 1'b1;
                #1 rst_n = 1'b0;
                #1;
                check("rst_sel_br",   32'(bus.sel_br),   32'h0);
                check("rst_id_valid", 32'(bus.id_valid), 32'h0);
                check("rst_pc_stall", 32'(bus.pc_stall), 32'h0);
                model_reset();
                @(posedge clk);
                #1 rst_n = 1'b1;
            end else begin
                @(posedge clk);
                model_step(ins, fpc, rdy);
            end
        end

        if (!did_rst) check("reset_in_redirect_reached", 32'h0, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
